// File: rtl/tb_util_pkg.sv
// Shared types and defaults for the sweep checker, plus small stimulus helpers.
package tb_util_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    localparam int DEFAULT_CNT_W = 16;

    // Pseudo-random byte sequence for stimulus generators.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sweep_checker.sv
// Checks that valid samples follow an arithmetic sweep start, start+step, ... <= stop,
// counting mismatches and reporting pass/fail once the sweep completes.
module sweep_checker
    import tb_util_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [W-1:0]     cfg_start_i,
    input  logic [W-1:0]     cfg_stop_i,
    input  logic [W-1:0]     cfg_step_i,
    input  logic             sample_valid_i,
    input  logic [W-1:0]     sample_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [W-1:0]     expected_o,
    output logic [W:0]       sample_count_o
);

    sweep_state_e r_state;
    sweep_state_e w_state_next;

    logic [W-1:0] r_expected;
    logic [W-1:0] r_stop;
    logic [W-1:0] r_step;
    logic [W:0]   r_sample_count;
    logic         r_err;

    logic         w_cfg_bad;
    logic         w_take;
    logic         w_mismatch;
    logic         w_last;
    logic [W:0]   w_next_sum;

    assign w_cfg_bad  = (cfg_step_i == '0) || (cfg_start_i > cfg_stop_i);
    // A start in the same cycle as a sample restarts the sweep and drops the sample.
    assign w_take     = (r_state == RUN) && sample_valid_i && !start_i;
    assign w_mismatch = (sample_i != r_expected);
    // One extra bit so a sweep ending near 2**W-1 terminates instead of wrapping.
    assign w_next_sum = {1'b0, r_expected} + {1'b0, r_step};
    assign w_last     = (w_next_sum > {1'b0, r_stop});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start_i) begin
            w_state_next = w_cfg_bad ? DONE : RUN;
        end else if (w_take && w_last) begin
            w_state_next = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected     <= '0;
            r_stop         <= '0;
            r_step         <= '0;
            r_sample_count <= '0;
            r_err          <= 1'b0;
        end else if (start_i) begin
            r_expected     <= cfg_start_i;
            r_stop         <= cfg_stop_i;
            r_step         <= cfg_step_i;
            r_sample_count <= '0;
            r_err          <= w_cfg_bad;
        end else if (w_take) begin
            r_sample_count <= r_sample_count + (W+1)'(1);
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
            if (!w_last) begin
                r_expected <= w_next_sum[W-1:0];
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_take && w_mismatch),
        .clear (start_i),
        .count (err_count_o)
    );

    assign busy_o         = (r_state == RUN);
    assign done_o         = (r_state == DONE);
    assign pass_o         = done_o && !r_err;
    assign err_o          = r_err;
    assign expected_o     = r_expected;
    assign sample_count_o = r_sample_count;

endmodule

// File: tb/tb_sweep_checker.sv
// Self-checking bench for sweep_checker: directed scenarios plus randomized traffic
// checked against a list-based model of the expected sweep.
module tb_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] cfg_start_i, cfg_stop_i, cfg_step_i;
    logic       sample_valid_i;
    logic [7:0] sample_i;

    logic        busy_o, done_o, pass_o, err_o;
    logic [15:0] err_count_o;
    logic [7:0]  expected_o;
    logic [8:0]  sample_count_o;

    logic        busy2, done2, pass2, err2;
    logic [1:0]  err_count2;
    logic [7:0]  expected2;
    logic [8:0]  sample_count2;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the full list of values the sweep should produce, and how far we are in it.
    int q_exp[$];
    int m_idx;
    bit m_busy, m_done, m_err;
    int m_errcnt, m_cnt, m_exp;

    sweep_checker #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_step_i(cfg_step_i),
        .sample_valid_i(sample_valid_i), .sample_i(sample_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_o(err_o),
        .err_count_o(err_count_o), .expected_o(expected_o), .sample_count_o(sample_count_o)
    );

    sweep_checker #(.W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_step_i(cfg_step_i),
        .sample_valid_i(sample_valid_i), .sample_i(sample_i),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_o(err2),
        .err_count_o(err_count2), .expected_o(expected2), .sample_count_o(sample_count2)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        if (rst) begin
            q_exp.delete();
            m_idx = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_errcnt = 0; m_cnt = 0; m_exp = 0;
        end else if (start_i) begin
            q_exp.delete();
            m_idx = 0; m_cnt = 0; m_errcnt = 0;
            m_exp = int'(cfg_start_i);
            if (cfg_step_i == 0 || cfg_start_i > cfg_stop_i) begin
                m_busy = 0; m_done = 1; m_err = 1;
            end else begin
                m_busy = 1; m_done = 0; m_err = 0;
                for (int v = int'(cfg_start_i); v <= int'(cfg_stop_i); v += int'(cfg_step_i))
                    q_exp.push_back(v);
            end
        end else if (m_busy && sample_valid_i) begin
            m_cnt++;
            if (int'(sample_i) != q_exp[m_idx]) begin
                m_err = 1;
                m_errcnt++;
            end
            m_idx++;
            if (m_idx == q_exp.size()) begin
                m_busy = 0; m_done = 1;
            end else begin
                m_exp = q_exp[m_idx];
            end
        end
    endtask

    task automatic cyc(input logic s, input logic [7:0] cs, input logic [7:0] ce,
                       input logic [7:0] cst, input logic v, input logic [7:0] smp,
                       input logic r);
        rst = r; start_i = s;
        cfg_start_i = cs; cfg_stop_i = ce; cfg_step_i = cst;
        sample_valid_i = v; sample_i = smp;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic start_sweep(input logic [7:0] cs, input logic [7:0] ce, input logic [7:0] cst);
        cyc(1'b1, cs, ce, cst, 1'b0, 8'h00, 1'b0);
    endtask

    // Live cfg inputs are scrambled while feeding to show they do not disturb the sweep.
    task automatic feed(input logic [7:0] smp);
        cyc(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, smp, 1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b1, 8'd5, 8'd9, 8'd1, 1'b1, 8'd5, 1'b1);
        cyc(1'b1, 8'd5, 8'd9, 8'd1, 1'b1, 8'd5, 1'b1);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else n_pass++;
        n_checks++; if (pass_o !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (err_count_o !== 16'd0) $display("FAIL reset_errcnt: got %0d want 0", err_count_o); else n_pass++;
        n_checks++; if (expected_o !== 8'd0) $display("FAIL reset_expected: got %0d want 0", expected_o); else n_pass++;
        n_checks++; if (sample_count_o !== 9'd0) $display("FAIL reset_count: got %0d want 0", sample_count_o); else n_pass++;
        cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_full_sweep();
        start_sweep(8'd0, 8'd255, 8'd1);
        for (int i = 0; i < 256; i++) begin
            feed(8'(i));
            if (i < 255) begin
                n_checks++;
                if (busy_o !== 1'b1 || expected_o !== 8'(i + 1))
                    $display("FAIL full_progress[%0d]: got busy=%b exp=%0d want busy=1 exp=%0d",
                             i, busy_o, expected_o, i + 1);
                else n_pass++;
            end
        end
        n_checks++; if (done_o !== 1'b1) $display("FAIL full_done: got %b want 1", done_o); else n_pass++;
        n_checks++; if (sample_count_o !== 9'd256) $display("FAIL full_count: got %0d want 256", sample_count_o); else n_pass++;
        n_checks++; if (pass_o !== 1'b1) $display("FAIL full_pass: got %b want 1", pass_o); else n_pass++;
        $display("test_full_sweep: count=%0d pass=%b", sample_count_o, pass_o);
    endtask

    task automatic test_mismatch();
        start_sweep(8'd10, 8'd50, 8'd10);
        feed(8'd10); feed(8'd20); feed(8'd99);
        n_checks++; if (err_o !== 1'b1 || err_count_o !== 16'd1)
            $display("FAIL mism_after_bad: got err=%b cnt=%0d want err=1 cnt=1", err_o, err_count_o); else n_pass++;
        feed(8'd40);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL mism_busy4: got %b want 1", busy_o); else n_pass++;
        feed(8'd50);
        n_checks++; if (done_o !== 1'b1 || sample_count_o !== 9'd5)
            $display("FAIL mism_done: got done=%b cnt=%0d want done=1 cnt=5", done_o, sample_count_o); else n_pass++;
        n_checks++; if (err_count_o !== 16'd1) $display("FAIL mism_errcnt: got %0d want 1", err_count_o); else n_pass++;
        n_checks++; if (pass_o !== 1'b0 || err_o !== 1'b1)
            $display("FAIL mism_pass: got pass=%b err=%b want pass=0 err=1", pass_o, err_o); else n_pass++;
        $display("test_mismatch: errcnt=%0d", err_count_o);
    endtask

    task automatic test_no_wrap();
        start_sweep(8'd250, 8'd255, 8'd4);
        feed(8'd250);
        n_checks++; if (busy_o !== 1'b1 || expected_o !== 8'd254)
            $display("FAIL nowrap_mid: got busy=%b exp=%0d want busy=1 exp=254", busy_o, expected_o); else n_pass++;
        feed(8'd254);
        n_checks++; if (done_o !== 1'b1 || pass_o !== 1'b1 || sample_count_o !== 9'd2)
            $display("FAIL nowrap_end: got done=%b pass=%b cnt=%0d want 1 1 2", done_o, pass_o, sample_count_o); else n_pass++;
        $display("test_no_wrap: done=%b", done_o);
    endtask

    task automatic test_cfg_error();
        start_sweep(8'd5, 8'd20, 8'd0);
        n_checks++; if (done_o !== 1'b1 || err_o !== 1'b1 || pass_o !== 1'b0 || sample_count_o !== 9'd0 || busy_o !== 1'b0)
            $display("FAIL cfg_step0: got done=%b err=%b pass=%b cnt=%0d busy=%b want 1 1 0 0 0",
                     done_o, err_o, pass_o, sample_count_o, busy_o); else n_pass++;
        start_sweep(8'd9, 8'd3, 8'd1);
        n_checks++; if (done_o !== 1'b1 || err_o !== 1'b1 || pass_o !== 1'b0 || sample_count_o !== 9'd0)
            $display("FAIL cfg_order: got done=%b err=%b pass=%b cnt=%0d want 1 1 0 0",
                     done_o, err_o, pass_o, sample_count_o); else n_pass++;
        $display("test_cfg_error: err=%b", err_o);
    endtask

    task automatic test_rst_mid();
        start_sweep(8'd0, 8'd100, 8'd1);
        feed(8'd0); feed(8'd7); feed(8'd2);
        n_checks++; if (sample_count_o !== 9'd3 || err_count_o !== 16'd1)
            $display("FAIL rstmid_pre: got cnt=%0d err=%0d want 3 1", sample_count_o, err_count_o); else n_pass++;
        cyc(1'b1, 8'd1, 8'd9, 8'd1, 1'b1, 8'd3, 1'b1);
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || err_count_o !== 16'd0 ||
                        expected_o !== 8'd0 || sample_count_o !== 9'd0 || pass_o !== 1'b0)
            $display("FAIL rstmid_post: got busy=%b done=%b err=%b ecnt=%0d exp=%0d cnt=%0d want all 0",
                     busy_o, done_o, err_o, err_count_o, expected_o, sample_count_o); else n_pass++;
        cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        $display("test_rst_mid done");
    endtask

    task automatic test_start_coincident();
        start_sweep(8'd0, 8'd100, 8'd2);
        feed(8'd0); feed(8'd5);
        cyc(1'b1, 8'd20, 8'd40, 8'd5, 1'b1, 8'd99, 1'b0);
        n_checks++; if (busy_o !== 1'b1 || sample_count_o !== 9'd0 || err_count_o !== 16'd0 ||
                        err_o !== 1'b0 || expected_o !== 8'd20)
            $display("FAIL restart: got busy=%b cnt=%0d ecnt=%0d err=%b exp=%0d want 1 0 0 0 20",
                     busy_o, sample_count_o, err_count_o, err_o, expected_o); else n_pass++;
        feed(8'd20);
        n_checks++; if (sample_count_o !== 9'd1 || expected_o !== 8'd25)
            $display("FAIL restart_next: got cnt=%0d exp=%0d want 1 25", sample_count_o, expected_o); else n_pass++;
        $display("test_start_coincident done");
    endtask

    task automatic test_ignore_outside_run();
        cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        n_checks++; if (sample_count_o !== 9'd0 || err_count_o !== 16'd0 || busy_o !== 1'b0)
            $display("FAIL idle_ignore: got cnt=%0d ecnt=%0d busy=%b want 0 0 0",
                     sample_count_o, err_count_o, busy_o); else n_pass++;
        start_sweep(8'd1, 8'd2, 8'd1);
        feed(8'd1); feed(8'd2);
        for (int i = 0; i < 4; i++) feed(8'd200);
        n_checks++; if (sample_count_o !== 9'd2 || err_count_o !== 16'd0 || pass_o !== 1'b1)
            $display("FAIL done_ignore: got cnt=%0d ecnt=%0d pass=%b want 2 0 1",
                     sample_count_o, err_count_o, pass_o); else n_pass++;
        $display("test_ignore_outside_run done");
    endtask

    task automatic test_saturation();
        start_sweep(8'd0, 8'd10, 8'd1);
        for (int i = 0; i < 11; i++) feed(8'd200);
        n_checks++; if (err_count_o !== 16'd11) $display("FAIL sat_wide: got %0d want 11", err_count_o); else n_pass++;
        n_checks++; if (err_count2 !== 2'd3) $display("FAIL sat_narrow: got %0d want 3", err_count2); else n_pass++;
        n_checks++; if (done_o !== 1'b1) $display("FAIL sat_done: got %b want 1", done_o); else n_pass++;
        $display("test_saturation: wide=%0d narrow=%0d", err_count_o, err_count2);
    endtask

    task automatic test_random();
        int mode, cs, ce, cst, ecnt_wide, ecnt_narrow;
        logic s, v, r;
        logic [7:0] smp;
        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 29) == 0) || (!m_busy && $urandom_range(0, 2) == 0);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                cs = $urandom_range(0, 255); ce = $urandom_range(cs, 255); cst = 0;
            end else if (mode == 1) begin
                cs = $urandom_range(1, 255); ce = $urandom_range(0, cs - 1); cst = $urandom_range(1, 9);
            end else if (mode == 2) begin
                cs = $urandom_range(240, 255); ce = 255; cst = $urandom_range(1, 16);
            end else begin
                cs = $urandom_range(0, 200); ce = cs + $urandom_range(0, 40); cst = $urandom_range(1, 8);
            end
            v = ($urandom_range(0, 9) < 7);
            smp = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(m_exp);
            cyc(s, 8'(cs), 8'(ce), 8'(cst), v, smp, r);
            ecnt_wide   = (m_errcnt > 65535) ? 65535 : m_errcnt;
            ecnt_narrow = (m_errcnt > 3) ? 3 : m_errcnt;
            n_checks++; if (busy_o !== m_busy) $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy_o, m_busy); else n_pass++;
            n_checks++; if (done_o !== m_done) $display("FAIL rnd_done[%0d]: got %b want %b", c, done_o, m_done); else n_pass++;
            n_checks++; if (pass_o !== (m_done && !m_err)) $display("FAIL rnd_pass[%0d]: got %b want %b", c, pass_o, m_done && !m_err); else n_pass++;
            n_checks++; if (err_o !== m_err) $display("FAIL rnd_err[%0d]: got %b want %b", c, err_o, m_err); else n_pass++;
            n_checks++; if (err_count_o !== 16'(ecnt_wide)) $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", c, err_count_o, ecnt_wide); else n_pass++;
            n_checks++; if (expected_o !== 8'(m_exp)) $display("FAIL rnd_expected[%0d]: got %0d want %0d", c, expected_o, m_exp); else n_pass++;
            n_checks++; if (sample_count_o !== 9'(m_cnt)) $display("FAIL rnd_count[%0d]: got %0d want %0d", c, sample_count_o, m_cnt); else n_pass++;
            n_checks++;
            if (busy2 !== m_busy || done2 !== m_done || pass2 !== (m_done && !m_err) || err2 !== m_err ||
                err_count2 !== 2'(ecnt_narrow) || expected2 !== 8'(m_exp) || sample_count2 !== 9'(m_cnt))
                $display("FAIL rnd_narrow[%0d]: got ecnt=%0d cnt=%0d exp=%0d busy=%b done=%b want ecnt=%0d cnt=%0d exp=%0d busy=%b done=%b",
                         c, err_count2, sample_count2, expected2, busy2, done2, ecnt_narrow, m_cnt, m_exp, m_busy, m_done);
            else n_pass++;
        end
        $display("test_random done");
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; sample_valid_i = 1'b0;
        cfg_start_i = '0; cfg_stop_i = '0; cfg_step_i = '0; sample_i = '0;
        test_reset();
        test_full_sweep();
        test_mismatch();
        test_no_wrap();
        test_cfg_error();
        test_rst_mid();
        test_start_coincident();
        test_ignore_outside_run();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sweep_checker.md
SWEEP_CHECKER -- requirements
Module: sweep_checker

Interface
REQ-001 SHALL have parameter W, default 8, meaning width in bits of the observed value.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the error counter.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  meaning one-cycle pulse that arms a new sweep check.
REQ-006 SHALL have port cfg_start_i  input  W  meaning first expected value, sampled on start_i.
REQ-007 SHALL have port cfg_stop_i  input  W  meaning last expected value (inclusive), sampled on start_i.
REQ-008 SHALL have port cfg_step_i  input  W  meaning increment, sampled on start_i.
REQ-009 SHALL have port sample_valid_i  input  1  meaning sample_i holds a new observed value this cycle.
REQ-010 SHALL have port sample_i  input  W  meaning observed value driven by the stimulus side.
REQ-011 SHALL have port busy_o  output  1  meaning sweep in progress.
REQ-012 SHALL have port done_o  output  1  meaning sweep finished; level, held until next start_i.
REQ-013 SHALL have port pass_o  output  1  meaning done_o and zero errors.
REQ-014 SHALL have port err_o  output  1  meaning sticky: at least one mismatch or config error this sweep.
REQ-015 SHALL have port err_count_o  output  CNT_W  meaning mismatch count, saturating.
REQ-016 SHALL have port expected_o  output  W  meaning value expected on the next valid sample.
REQ-017 SHALL have port sample_count_o  output  W+1  meaning valid samples consumed this sweep.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE/DONE + start_i SHALL load expected_o=cfg_start_i, clear err_o, err_count_o, sample_count_o, done_o, and enter RUN next cycle.
REQ-020 start_i with cfg_step_i==0 or cfg_start_i>cfg_stop_i SHALL go directly to DONE with err_o=1, pass_o=0, sample_count_o=0.
REQ-021 In RUN, each sample_valid_i SHALL increment sample_count_o; sample_i!=expected_o SHALL set err_o and increment err_count_o, both visible the next cycle.
REQ-022 err_count_o SHALL saturate at 2**CNT_W-1.
REQ-023 Next expected SHALL be computed as expected_o+cfg_step in W+1 bits; if result > cfg_stop, the current sample is the last one and the FSM SHALL enter DONE the next cycle; otherwise expected_o SHALL take the result.
REQ-024 W+1-bit arithmetic SHALL prevent wrap-around: full-range sweep 0..2**W-1 step 1 SHALL end after exactly 2**W samples.
REQ-025 sample_valid_i outside RUN SHALL be ignored (no count, no error).
REQ-026 start_i in RUN SHALL abort and restart per REQ-019; simultaneous sample_valid_i SHALL be ignored.
REQ-027 busy_o SHALL equal (state==RUN); done_o SHALL equal (state==DONE).
REQ-028 pass_o SHALL equal done_o AND NOT err_o.

Reset
REQ-029 rst SHALL force IDLE, busy_o=0, done_o=0, pass_o=0, err_o=0, err_count_o=0, expected_o=0, sample_count_o=0.
REQ-030 rst SHALL override start_i and sample_valid_i in the same cycle, including mid-sweep.

Structure
REQ-031 State enum (IDLE/RUN/DONE) and default CNT_W SHALL live in shared package tb_util_pkg alongside existing stimulus helpers.
REQ-032 Saturating counter SHALL be a sub-module sat_counter (parameter width, inc, clear).
REQ-033 cfg_stop and cfg_step SHALL be registered on start_i; live cfg inputs SHALL NOT affect a running sweep.

Verification (W=8, CNT_W=16)
REQ-034 start 0, stop 255, step 1, feed 0..255 one per cycle -> done_o one cycle after 256th sample, sample_count_o=256, pass_o=1.
REQ-035 start 10, stop 50, step 10, feed 10,20,99,40,50 -> err_count_o=1, err_o=1, done_o after 5 samples, pass_o=0.
REQ-036 start 250, stop 255, step 4, feed 250,254 -> DONE after 2 samples (258>255, no wrap), pass_o=1.
REQ-037 step 0 or start 9 > stop 3 -> DONE next cycle, err_o=1, sample_count_o=0.
REQ-038 rst mid-sweep after 3 samples, and start_i coincident with sample_valid_i -> all outputs to reset values / restart with counts cleared, sample ignored.
REQ-039 sample_valid_i in IDLE and DONE -> no change to sample_count_o or err_count_o.
